muller_c_element: RTL and testbench

//  Clocked Muller C-element (rendezvous/consensus gate) for the asynchronous-style

---
 rtl/handshake_pkg.sv | 30 +++
 rtl/c_element_lane.sv | 54 +++++
 rtl/muller_c_element.sv | 49 ++++
 tb/tb_muller_c_element.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// ---------------------------------------------------------------------------
// handshake_pkg
//   Shared definitions for the handshake merge logic.
//   - lane_state_t : state held by one C-element lane (low or high).
//   - c_next       : next value of one lane given its effective inputs and
//                    its current value.
// ---------------------------------------------------------------------------
package handshake_pkg;

  typedef enum logic {
    C_LOW  = 1'b0,
    C_HIGH = 1'b1
  } lane_state_t;

  // Rendezvous rule for one lane: both high sets it, both low clears it,
  // and anything else holds. Equality tests are used rather than a boolean
  // reduction so that an unknown input falls through to the hold branch
  // instead of pushing an unknown into the register.
  function automatic logic c_next(input logic ea, input logic eb, input logic cur);
    logic nxt;
    nxt = cur;
    if (ea == 1'b1 && eb == 1'b1) begin
      nxt = 1'b1;
    end else if (ea == 1'b0 && eb == 1'b0) begin
      nxt = 1'b0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/c_element_lane.sv
// ---------------------------------------------------------------------------
// c_element_lane
//   One registered Muller C-element lane with optional input inversion.
//   Ports:
//     clk    - rising-edge clock
//     rst    - asynchronous, active-high reset (loads RESET_VAL)
//     a, b   - rendezvous inputs (inverted by INV_A / INV_B when set)
//     c      - registered lane output, driven only by the state register
//     agree  - combinational: effective inputs are equal (lane will update)
// ---------------------------------------------------------------------------
module c_element_lane
  import handshake_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0,
  parameter logic INV_A     = 1'b0,
  parameter logic INV_B     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic c,
  output logic agree
);

  logic        ea;
  logic        eb;
  lane_state_t state_q;

  assign ea = a ^ INV_A;
  assign eb = b ^ INV_B;

  // Lane hold register. Reset is asynchronous so c returns to RESET_VAL
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= lane_state_t'(RESET_VAL);
    end else begin
      state_q <= lane_state_t'(c_next(ea, eb, state_q == C_HIGH));
    end
  end

  assign c = (state_q == C_HIGH);

  // An unknown on either input makes the comparison unknown, which takes
  // the default branch and reports disagreement.
  always_comb begin
    agree = 1'b0;
    if (ea == eb) begin
      agree = 1'b1;
    end
  end

endmodule

// File: rtl/muller_c_element.sv
// ---------------------------------------------------------------------------
// muller_c_element
//   WIDTH independent clocked Muller C-element lanes used to join req/ack
//   terms in the handshake merge blocks.
//   Parameters:
//     WIDTH     - number of lanes
//     RESET_VAL - value loaded into c on reset
//     INV_A     - per-lane inversion mask for a
//     INV_B     - per-lane inversion mask for b
//   Ports:
//     clk    - rising-edge clock
//     rst    - asynchronous, active-high reset
//     a, b   - rendezvous inputs, one bit per lane
//     c      - registered C-element outputs
//     agree  - combinational per-lane "effective inputs are equal"
// ---------------------------------------------------------------------------
module muller_c_element
  import handshake_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] INV_A     = '0,
  parameter logic [WIDTH-1:0] INV_B     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] agree
);

  // Lanes never interact, so each bit gets its own self-contained element.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    c_element_lane #(
      .RESET_VAL (RESET_VAL[i]),
      .INV_A     (INV_A[i]),
      .INV_B     (INV_B[i])
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .a     (a[i]),
      .b     (b[i]),
      .c     (c[i]),
      .agree (agree[i])
    );
  end

endmodule

// File: tb/tb_muller_c_element.sv
// ---------------------------------------------------------------------------
// tb_muller_c_element
//   Drives three configurations (1 lane plain, 1 lane with b inverted,
//   4 lanes plain) from one clock and reset. Expected c values are pushed
//   to a scoreboard when inputs are driven and popped after the next edge.
// ---------------------------------------------------------------------------
module tb_muller_c_element;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, ai, bi;
  logic [3:0] a4, b4;
  logic       c1, g1, ci, gi;
  logic [3:0] c4, g4;

  logic       m1, mi;
  logic [3:0] m4;

  typedef struct {
    string      tag;
    int         unit_id;
    logic [3:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muller_c_element #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .agree(g1)
  );

  muller_c_element #(.WIDTH(1), .INV_B(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .a(ai), .b(bi), .c(ci), .agree(gi)
  );

  muller_c_element #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .agree(g4)
  );

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Reference: a lane whose inputs are known and equal takes that value,
  // every other lane keeps its current value.
  function automatic logic [3:0] model_next(input logic [3:0] ea, input logic [3:0] eb,
                                            input logic [3:0] cur, input int w);
    logic [3:0] r;
    r = cur;
    for (int i = 0; i < w; i++) begin
      if ((ea[i] ^ eb[i]) === 1'b0) r[i] = ea[i];
    end
    return r;
  endfunction

  function automatic logic [3:0] model_agree(input logic [3:0] ea, input logic [3:0] eb, input int w);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < w; i++) begin
      r[i] = ((ea[i] ^ eb[i]) === 1'b0);
    end
    return r;
  endfunction

  task automatic applyStimulus(input string tag, input logic r,
                               input logic na1, input logic nb1,
                               input logic nai, input logic nbi,
                               input logic [3:0] na4, input logic [3:0] nb4);
    sb_entry_t  e;
    logic [3:0] t;
    @(negedge clk);
    rst = r;
    a1  = na1;
    b1  = nb1;
    ai  = nai;
    bi  = nbi;
    a4  = na4;
    b4  = nb4;
    if (r) begin
      m1 = 1'b0;
      mi = 1'b0;
      m4 = 4'b0000;
    end else begin
      t  = model_next({3'b000, a1}, {3'b000, b1}, {3'b000, m1}, 1);
      m1 = t[0];
      t  = model_next({3'b000, ai}, {3'b000, ~bi}, {3'b000, mi}, 1);
      mi = t[0];
      m4 = model_next(a4, b4, m4, 4);
    end
    sb_q.push_back('{tag: {tag, "/c1"},   unit_id: 0, exp: {3'b000, m1}});
    sb_q.push_back('{tag: {tag, "/cinv"}, unit_id: 1, exp: {3'b000, mi}});
    sb_q.push_back('{tag: {tag, "/c4"},   unit_id: 2, exp: m4});
    #1;
    checkOutput({tag, "/agree1"},   {3'b000, g1}, model_agree({3'b000, a1}, {3'b000, b1}, 1));
    checkOutput({tag, "/agreeinv"}, {3'b000, gi}, model_agree({3'b000, ai}, {3'b000, ~bi}, 1));
    checkOutput({tag, "/agree4"},   g4,           model_agree(a4, b4, 4));
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.unit_id)
        0:       checkOutput(e.tag, {3'b000, c1}, e.exp);
        1:       checkOutput(e.tag, {3'b000, ci}, e.exp);
        default: checkOutput(e.tag, c4, e.exp);
      endcase
    end
  endtask

  initial begin
    rst = 1'b0;
    a1  = 1'b1;
    b1  = 1'b1;
    ai  = 1'b0;
    bi  = 1'b0;
    a4  = 4'b0000;
    b4  = 4'b0000;
    m1  = 1'b0;
    mi  = 1'b0;
    m4  = 4'b0000;

    // Reset asserted between edges with a=b=1: c clears before any clock.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_now/c1",   {3'b000, c1}, 4'b0000);
    checkOutput("rst_now/cinv", {3'b000, ci}, 4'b0000);
    checkOutput("rst_now/c4",   c4,           4'b0000);

    // Held in reset across edges even though inputs agree high.
    applyStimulus("rst_hold0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111);
    applyStimulus("rst_hold1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111);

    // Rendezvous on dut1; inversion on dut_inv; multi-lane on dut4.
    applyStimulus("rdv_a_only0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b0110);
    applyStimulus("rdv_a_only1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b1010);
    applyStimulus("rdv_both",    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, 4'b1010);
    applyStimulus("rdv_drop_a",  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b1010);
    applyStimulus("rdv_drop_b",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);

    // Bring dut1 back to 1, then assert reset mid-cycle.
    applyStimulus("pre_async", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111);
    #3;
    rst = 1'b1;
    m1  = 1'b0;
    mi  = 1'b0;
    m4  = 4'b0000;
    #1;
    checkOutput("async_rst/c1",   {3'b000, c1}, {3'b000, m1});
    checkOutput("async_rst/cinv", {3'b000, ci}, {3'b000, mi});
    checkOutput("async_rst/c4",   c4,           m4);

    // Release with inputs already agreeing high: first edge sets c.
    applyStimulus("rst_release", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111);
    applyStimulus("repeat_agree", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111);

    // Unknown input from c=0: lane holds and reports disagreement.
    applyStimulus("to_zero", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    applyStimulus("x_in",    1'b0, 1'bx, 1'b1, 1'bx, 1'b0, 4'b0000, 4'b1111);
    applyStimulus("x_clear", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b1001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
